// File: rtl/tsc_mon_pkg.sv
// Shared types and helpers for the TSC load-bus monitor.
// Contents: FSM state enum, default replica LFSR seed/taps, and the LFSR
// next-state function used by the replica counter.
package tsc_mon_pkg;

  localparam int unsigned CNT_W_DEF     = 20;
  localparam logic [19:0] LFSR_SEED_DEF = 20'h00001;
  localparam logic [19:0] LFSR_TAPS_DEF = 20'h90000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ALARM = 2'd2
  } mon_state_e;

  // Fibonacci step on a 32-bit container: shift left, feedback into bit 0.
  // Callers truncate the result to their own counter width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur,
                                            input logic [31:0] taps);
    return {cur[30:0], ^(cur & taps)};
  endfunction

endpackage

// File: rtl/tsc_load_monitor_if.sv
// Observation bundle between the leakage bus and the load monitor.
// Inputs to the monitor: trig_obs, load, clr_alarm.
// Outputs from the monitor: decoded, decoded_valid, lane_incoherent,
// stable_cnt, alarm, state.
interface tsc_load_monitor_if #(
  parameter int unsigned SC_W = 8
);
  logic            trig_obs;
  logic [63:0]     load;
  logic            clr_alarm;
  logic [7:0]      decoded;
  logic            decoded_valid;
  logic [7:0]      lane_incoherent;
  logic [SC_W-1:0] stable_cnt;
  logic            alarm;
  logic [1:0]      state;

  modport master (
    output trig_obs, load, clr_alarm,
    input  decoded, decoded_valid, lane_incoherent, stable_cnt, alarm, state
  );

  modport slave (
    input  trig_obs, load, clr_alarm,
    output decoded, decoded_valid, lane_incoherent, stable_cnt, alarm, state
  );
endinterface

// File: rtl/tsc_replica_lfsr.sv
// Replica of the payload's trigger-stepped LFSR counter plus a one-cycle
// delayed copy that lines up with the payload's registered load bus.
// Ports: clk, rst (sync, active-high), en (step enable),
//        cnt_d1 (counter value registered once).
module tsc_replica_lfsr
  import tsc_mon_pkg::*;
#(
  parameter int unsigned          CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0]     LFSR_SEED = CNT_W'(LFSR_SEED_DEF),
  parameter logic [CNT_W-1:0]     LFSR_TAPS = CNT_W'(LFSR_TAPS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_d1
);

  logic [CNT_W-1:0] lfsr;

  // Counter and its one-cycle-late copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= LFSR_SEED;
      cnt_d1 <= LFSR_SEED;
    end else begin
      if (en) begin
        lfsr <= CNT_W'(lfsr_next(32'(lfsr), 32'(LFSR_TAPS)));
      end
      cnt_d1 <= lfsr;
    end
  end

  // A zero state is a lock-up point; only reachable from an illegal zero seed.
  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (rst) (lfsr != '0));

endmodule

// File: rtl/tsc_load_monitor.sv
// Runtime detector for the TSC trojan load-bus leak. Unmasks each byte lane
// with a replica LFSR, checks lane coherence, and raises a sticky alarm when
// the same coherent value persists for THRESH cycles.
// Ports: clk, rst (sync, active-high), mon (slave side of
//        tsc_load_monitor_if: trig_obs/load/clr_alarm in, decode status out).
module tsc_load_monitor
  import tsc_mon_pkg::*;
#(
  parameter int unsigned      CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] LFSR_SEED = CNT_W'(LFSR_SEED_DEF),
  parameter logic [CNT_W-1:0] LFSR_TAPS = CNT_W'(LFSR_TAPS_DEF),
  parameter int unsigned      THRESH    = 16,
  parameter int unsigned      SC_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  tsc_load_monitor_if.slave   mon
);

  localparam int unsigned     LANES    = 8;
  localparam int unsigned     LANE_W   = 8;
  localparam logic [SC_W-1:0] SC_MAX   = '1;
  localparam logic [SC_W-1:0] THRESH_V = SC_W'(THRESH);

  logic [CNT_W-1:0] cnt_d1;
  mon_state_e       state_q, state_d;
  logic [7:0]       decoded_q, decoded_d;
  logic             valid_q, valid_d;
  logic [7:0]       incoh_q, incoh_c;
  logic [SC_W-1:0]  stable_q, stable_d;
  logic             alarm_q, alarm_d;
  logic [7:0]       prev_q, prev_d;
  logic [7:0]       raw_c;
  logic             unused_cnt_bits;

  // The payload steps its counter on every trigger edge; IDLE is only
  // re-entered via rst, so stepping on trig_obs alone keeps the replica aligned.
  tsc_replica_lfsr #(
    .CNT_W     (CNT_W),
    .LFSR_SEED (LFSR_SEED),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en     (mon.trig_obs),
    .cnt_d1 (cnt_d1)
  );

  assign unused_cnt_bits = ^cnt_d1[CNT_W-1:8];

  // Per-lane coherence and unmasked bit.
  always_comb begin
    incoh_c = '0;
    raw_c   = '0;
    for (int i = 0; i < LANES; i++) begin
      incoh_c[i] = (|mon.load[LANE_W*i +: LANE_W]) & ~(&mon.load[LANE_W*i +: LANE_W]);
      raw_c[i]   = mon.load[LANE_W*i] ^ cnt_d1[i];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    decoded_d = decoded_q;
    valid_d   = 1'b0;
    stable_d  = stable_q;
    alarm_d   = alarm_q;
    prev_d    = prev_q;
    case (state_q)
      ST_IDLE: begin
        decoded_d = '0;
        stable_d  = '0;
        alarm_d   = 1'b0;
        if (mon.trig_obs) begin
          state_d = ST_TRACK;
        end
      end
      ST_TRACK, ST_ALARM: begin
        decoded_d = raw_c;
        if (incoh_c == '0) begin
          valid_d = 1'b1;
          prev_d  = raw_c;
          if (raw_c == prev_q) begin
            stable_d = (stable_q == SC_MAX) ? stable_q : stable_q + SC_W'(1);
          end else begin
            stable_d = SC_W'(1);
          end
        end else begin
          stable_d = '0;
        end
        if (state_q == ST_TRACK && stable_d == THRESH_V) begin
          alarm_d = 1'b1;
          state_d = ST_ALARM;
        end
        // Clear wins over an alarm raised on the same edge.
        if (mon.clr_alarm) begin
          alarm_d  = 1'b0;
          stable_d = '0;
          state_d  = ST_TRACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      decoded_q <= '0;
      valid_q   <= 1'b0;
      incoh_q   <= '0;
      stable_q  <= '0;
      alarm_q   <= 1'b0;
      prev_q    <= '0;
    end else begin
      state_q   <= state_d;
      decoded_q <= decoded_d;
      valid_q   <= valid_d;
      incoh_q   <= incoh_c;
      stable_q  <= stable_d;
      alarm_q   <= alarm_d;
      prev_q    <= prev_d;
    end
  end

  assign mon.decoded         = decoded_q;
  assign mon.decoded_valid   = valid_q;
  assign mon.lane_incoherent = incoh_q;
  assign mon.stable_cnt      = stable_q;
  assign mon.alarm           = alarm_q;
  assign mon.state           = 2'(state_q);

endmodule
